// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - modulo up/down counter with load, saturate option and sticky limit flags
module updown_mod_counter #(
  parameter int              WIDTH       = 8,
  parameter longint unsigned MAX_COUNT   = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE    = 1'b0,
  parameter longint unsigned RESET_VALUE = 64'd0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  input  logic             up,
  input  logic             down,
  input  logic             ovf_ack,
  output logic [WIDTH-1:0] Q_out,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VALUE);

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   pre_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH-1:0] next_q;
  logic             next_tc;
  logic             set_ovf;
  logic             set_udf;

  // One extra bit keeps MAX_COUNT = 2**WIDTH-1 comparisons and the borrow free of truncation.
  always_comb begin
    cnt_ext = {1'b0, Q_out};
    pre_ext = {1'b0, preset};
    inc_ext = cnt_ext + ONE_EXT;
    dec_ext = cnt_ext - ONE_EXT;
    next_q  = Q_out;
    next_tc = 1'b0;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    if (load) begin
      next_q = (pre_ext > MAX_EXT) ? MAX_Q : preset;
    end else if (enable && (up ^ down)) begin
      if (up) begin
        if (inc_ext > MAX_EXT) begin
          next_q  = SATURATE ? MAX_Q : '0;
          next_tc = 1'b1;
          set_ovf = 1'b1;
        end else begin
          next_q = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (dec_ext[WIDTH]) begin
          next_q  = SATURATE ? '0 : MAX_Q;
          next_tc = 1'b1;
          set_udf = 1'b1;
        end else begin
          next_q = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  // A flag being set on the same edge as an acknowledge stays set.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      Q_out <= RST_Q;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      Q_out <= next_q;
      tc    <= next_tc;
      ovf   <= set_ovf | (ovf & ~ovf_ack);
      udf   <= set_udf | (udf & ~ovf_ack);
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - three counter configurations checked against an arithmetic model
`timescale 1ns/1ps
module tb_updown_mod_counter;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] preset = 8'd0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       ovf_ack = 1'b0;

  logic [7:0] q_o [3];
  logic       tc_o [3];
  logic       ovf_o [3];
  logic       udf_o [3];

  int checks = 0;
  int failures = 0;

  // Instance 0: full-range wrap, 1: full-range saturate, 2: modulo-10 wrap with reset value 3.
  int maxv [3] = '{255, 255, 9};
  int satv [3] = '{0, 1, 0};
  int rstv [3] = '{0, 0, 3};

  int mq [3];
  int mtc [3];
  int movf [3];
  int mudf [3];

  always #5 clock = ~clock;

  updown_mod_counter #(.WIDTH(8), .MAX_COUNT(255), .SATURATE(1'b0), .RESET_VALUE(0)) d0 (
    .clock(clock), .clear(clear), .enable(enable), .load(load), .preset(preset), .up(up),
    .down(down), .ovf_ack(ovf_ack), .Q_out(q_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .udf(udf_o[0]));
  updown_mod_counter #(.WIDTH(8), .MAX_COUNT(255), .SATURATE(1'b1), .RESET_VALUE(0)) d1 (
    .clock(clock), .clear(clear), .enable(enable), .load(load), .preset(preset), .up(up),
    .down(down), .ovf_ack(ovf_ack), .Q_out(q_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .udf(udf_o[1]));
  updown_mod_counter #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(1'b0), .RESET_VALUE(3)) d2 (
    .clock(clock), .clear(clear), .enable(enable), .load(load), .preset(preset), .up(up),
    .down(down), .ovf_ack(ovf_ack), .Q_out(q_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]), .udf(udf_o[2]));

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clock or posedge clear) begin
    for (int i = 0; i < 3; i++) begin
      int nq;
      int t;
      int so;
      int su;
      if (clear) begin
        mq[i] = rstv[i]; mtc[i] = 0; movf[i] = 0; mudf[i] = 0;
      end else begin
        nq = mq[i]; t = 0; so = 0; su = 0;
        if (load) begin
          nq = (int'(preset) > maxv[i]) ? maxv[i] : int'(preset);
        end else if (enable && (up != down)) begin
          if (up) begin
            if (mq[i] == maxv[i]) begin t = 1; so = 1; nq = satv[i] ? maxv[i] : 0; end
            else nq = mq[i] + 1;
          end else begin
            if (mq[i] == 0) begin t = 1; su = 1; nq = satv[i] ? 0 : maxv[i]; end
            else nq = mq[i] - 1;
          end
        end
        mq[i] = nq;
        mtc[i] = t;
        movf[i] = (so != 0 || (movf[i] != 0 && !ovf_ack)) ? 1 : 0;
        mudf[i] = (su != 0 || (mudf[i] != 0 && !ovf_ack)) ? 1 : 0;
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_q%0d", i), int'(q_o[i]), mq[i]);
      chk($sformatf("model_tc%0d", i), int'(tc_o[i]), mtc[i]);
      chk($sformatf("model_ovf%0d", i), int'(ovf_o[i]), movf[i]);
      chk($sformatf("model_udf%0d", i), int'(udf_o[i]), mudf[i]);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1 clear = 1'b1;
    #1;
    chk("rst_q0", int'(q_o[0]), 0);
    chk("rst_q2", int'(q_o[2]), 3);
    chk("rst_tc0", int'(tc_o[0]), 0);
    chk("rst_ovf0", int'(ovf_o[0]), 0);
    chk("rst_udf0", int'(udf_o[0]), 0);
    step();
    clear = 1'b0;

    // Up-wrap through FF on the full-range wrap counter
    load = 1'b1; preset = 8'hFE;
    step();
    chk("load_fe_q0", int'(q_o[0]), 254);
    chk("load_fe_q2_clamp", int'(q_o[2]), 9);
    load = 1'b0; enable = 1'b1; up = 1'b1;
    step();
    chk("wrap_q_ff", int'(q_o[0]), 255);
    chk("wrap_tc_ff", int'(tc_o[0]), 0);
    step();
    chk("wrap_q_00", int'(q_o[0]), 0);
    chk("wrap_tc_00", int'(tc_o[0]), 1);
    chk("wrap_ovf_00", int'(ovf_o[0]), 1);
    step();
    chk("wrap_q_01", int'(q_o[0]), 1);
    chk("wrap_tc_01", int'(tc_o[0]), 0);
    chk("wrap_ovf_01", int'(ovf_o[0]), 1);

    // Modulo-10 counter: clamped load, wrap up, wrap down
    load = 1'b1; preset = 8'd15;
    step();
    chk("mod_load_q", int'(q_o[2]), 9);
    chk("mod_load_tc", int'(tc_o[2]), 0);
    load = 1'b0;
    step();
    chk("mod_up_q", int'(q_o[2]), 0);
    chk("mod_up_tc", int'(tc_o[2]), 1);
    up = 1'b0; down = 1'b1;
    step();
    chk("mod_dn_q", int'(q_o[2]), 9);
    chk("mod_dn_udf", int'(udf_o[2]), 1);

    // Saturating down at zero, then acknowledge
    clear = 1'b1; #2 clear = 1'b0;
    step();
    chk("sat_dn1_q", int'(q_o[1]), 0);
    chk("sat_dn1_tc", int'(tc_o[1]), 1);
    step();
    chk("sat_dn2_q", int'(q_o[1]), 0);
    chk("sat_dn2_tc", int'(tc_o[1]), 1);
    chk("sat_dn2_udf", int'(udf_o[1]), 1);
    down = 1'b0; ovf_ack = 1'b1;
    step();
    chk("sat_ack_udf", int'(udf_o[1]), 0);
    ovf_ack = 1'b0;

    // Hold cases
    load = 1'b1; preset = 8'h40;
    step();
    load = 1'b0; enable = 1'b0; up = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_en0_q", int'(q_o[0]), 64);
      chk("hold_en0_tc", int'(tc_o[0]), 0);
    end
    enable = 1'b1; down = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_both_q", int'(q_o[0]), 64);
      chk("hold_both_tc", int'(tc_o[0]), 0);
    end
    down = 1'b0;

    // Asynchronous clear while counting at 7F
    load = 1'b1; preset = 8'h7E;
    step();
    load = 1'b0;
    step();
    chk("pre_clr_q", int'(q_o[0]), 127);
    #1 clear = 1'b1;
    #1;
    chk("async_clr_q0", int'(q_o[0]), 0);
    chk("async_clr_q2", int'(q_o[2]), 3);
    chk("async_clr_ovf", int'(ovf_o[0]), 0);
    chk("async_clr_udf", int'(udf_o[2]), 0);
    #1 clear = 1'b0;
    step();
    chk("post_clr_q", int'(q_o[0]), 1);

    // Clear cuts a tc pulse short
    load = 1'b1; preset = 8'hFF;
    step();
    load = 1'b0;
    step();
    chk("tc_before_cut", int'(tc_o[0]), 1);
    clear = 1'b1;
    #1;
    chk("tc_cut", int'(tc_o[0]), 0);
    clear = 1'b0;

    // Set wins over acknowledge on the same edge
    load = 1'b1; preset = 8'hFF;
    step();
    load = 1'b0; ovf_ack = 1'b1;
    step();
    chk("coll_q", int'(q_o[0]), 0);
    chk("coll_ovf", int'(ovf_o[0]), 1);
    chk("coll_sat_q", int'(q_o[1]), 255);
    up = 1'b0; ovf_ack = 1'b0;
    step();
    chk("coll_ovf_kept", int'(ovf_o[0]), 1);
    ovf_ack = 1'b1;
    step();
    chk("coll_ovf_acked", int'(ovf_o[0]), 0);
    ovf_ack = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
